// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding and default widths.
package fetch_pkg;

  localparam int unsigned FETCH_N = 32;
  localparam int unsigned FETCH_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FLUSH = 3'd4,
    S_REDIR = 3'd5
  } state_e;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction holding register; loads in one cycle, output registered.
// Holds contents until accept or clear; clear wins over load.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned N = FETCH_N,
  parameter int unsigned W = FETCH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         accept,
  input  logic [W-1:0] ld_data,
  input  logic [N-1:0] ld_pc,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [N-1:0] pc
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [N-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear || accept) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      pc_d    = ld_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign pc    = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: one read per PC, 3-cycle turn with 1-cycle memory; mem_req/mem_addr combinational.
// Stalls in HOLD while decode withholds ins_ready; redirects load the PC and drain stale reads.
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned N = FETCH_N,
  parameter int unsigned W = FETCH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         halt,
  input  logic [N-1:0] pc_in,
  output logic         pc_load,
  output logic         pc_inc,
  output logic [N-1:0] pc_data,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [W-1:0] mem_rdata,
  input  logic         br_valid,
  input  logic [N-1:0] br_target,
  output logic         ins_valid,
  output logic [W-1:0] ins_data,
  output logic [N-1:0] ins_pc,
  input  logic         ins_ready
);

  state_e       state_q, state_d;
  logic [N-1:0] fetch_addr_q, fetch_addr_d;
  logic         pc_load_q, pc_load_d;
  logic         pc_inc_q, pc_inc_d;
  logic [N-1:0] pc_data_q, pc_data_d;
  logic         buf_load, buf_clear, buf_accept;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_load_d    = 1'b0;
    pc_inc_d     = 1'b0;
    pc_data_d    = pc_data_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;
    buf_accept   = 1'b0;

    if (br_valid) begin
      pc_load_d = 1'b1;
      pc_data_d = br_target;
      buf_clear = 1'b1;
    end

    case (state_q)
      // A redirect in IDLE defers start so the next REQ sees the loaded PC.
      S_IDLE: if (start && !br_valid) state_d = S_REQ;
      S_REQ: begin
        if (br_valid) begin
          state_d = mem_gnt ? S_FLUSH : S_REDIR;
        end else if (mem_gnt) begin
          state_d      = S_WAIT;
          fetch_addr_d = pc_in;
        end
      end
      S_WAIT: begin
        if (br_valid) begin
          state_d = mem_rvalid ? S_REDIR : S_FLUSH;
        end else if (mem_rvalid) begin
          buf_load = 1'b1;
          pc_inc_d = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (br_valid) begin
          state_d = S_REDIR;
        end else if (ins_valid && ins_ready) begin
          buf_accept = 1'b1;
          state_d    = halt ? S_IDLE : S_REQ;
        end
      end
      // Orphan drained together with a new redirect: give the counter its load cycle.
      S_FLUSH: if (mem_rvalid) state_d = br_valid ? S_REDIR : S_REQ;
      S_REDIR: if (!br_valid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      pc_load_q    <= 1'b0;
      pc_inc_q     <= 1'b0;
      pc_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_load_q    <= pc_load_d;
      pc_inc_q     <= pc_inc_d;
      pc_data_q    <= pc_data_d;
    end
  end

  fetch_buf #(.N(N), .W(W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .clear   (buf_clear),
    .accept  (buf_accept),
    .ld_data (mem_rdata),
    .ld_pc   (fetch_addr_q),
    .valid   (ins_valid),
    .data    (ins_data),
    .pc      (ins_pc)
  );

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = mem_req ? pc_in : '0;
  assign pc_load  = pc_load_q;
  assign pc_inc   = pc_inc_q;
  assign pc_data  = pc_data_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Harness: pc_fetch_ctrl with a behavioural PC counter and a fixed-latency memory model.
module tb_pc_fetch_ctrl;

  typedef logic [135:0] w_t;

  typedef struct {
    logic        start;
    logic        halt;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_ipc;
    logic [31:0] exp_idat;
    logic        exp_inc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt, ins_ready, br_valid;
  logic [31:0] br_target;
  logic [31:0] pc_in;
  logic        pc_load, pc_inc;
  logic [31:0] pc_data;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        ins_valid;
  logic [31:0] ins_data, ins_pc;

  int          checks = 0;
  int          failures = 0;
  int          inc_cnt = 0;
  int          lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  vec_t        tv [15];

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt       (halt),
    .pc_in      (pc_in),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .pc_data    (pc_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .ins_valid  (ins_valid),
    .ins_data   (ins_data),
    .ins_pc     (ins_pc),
    .ins_ready  (ins_ready)
  );

  // Program counter as the controller sees it: load wins, else increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc_in <= '0;
    else if (pc_load) pc_in <= pc_data;
    else if (pc_inc)  pc_in <= pc_in + 32'd1;
  end

  task automatic chk(input string name, input w_t got, input w_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic w_t outs();
    return w_t'({mem_req, mem_addr, pc_load, pc_inc, pc_data, ins_valid, ins_pc, ins_data});
  endfunction

  // Memory: word[a] = 0x1000 + a, rvalid 'lat' cycles after the grant, one outstanding.
  task automatic mem_step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1000 + pend_addr;
      end
    end
    mem_gnt = mem_req && (pend_cnt == 0);
    if (mem_gnt) begin
      pend_cnt  = lat;
      pend_addr = mem_addr;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mem_step();
    if (pc_inc) inc_cnt++;
    chk("excl_load_inc", w_t'(pc_load & pc_inc), w_t'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; ins_ready = 1'b0;
    br_valid = 1'b0; br_target = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    //          start halt rdy | req  addr   iv   ipc    idat        inc
    tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, 32'h1000, 1'b1};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, 32'h1001, 1'b1};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd2, 32'h1002, 1'b1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'd3, 32'h1003, 1'b1};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,    1'b0};
    tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0,    1'b0};

    repeat (2) @(negedge clk);
    chk("reset_state", outs(), w_t'(0));
    rst = 1'b0;

    // Sequential fetch from PC 0, then halt on the fourth acceptance.
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk($sformatf("seq_vec%0d", i),
          w_t'({mem_req, mem_addr, ins_valid,
                tv[i].exp_iv ? ins_pc : 32'd0, tv[i].exp_iv ? ins_data : 32'd0, pc_inc}),
          w_t'({tv[i].exp_req, tv[i].exp_addr, tv[i].exp_iv,
                tv[i].exp_ipc, tv[i].exp_idat, tv[i].exp_inc}));
      start     = tv[i].start;
      halt      = tv[i].halt;
      ins_ready = tv[i].rdy;
    end

    // Backpressure: instruction at PC 4 held while decode stalls.
    start = 1'b1;
    cyc(); chk("bp_req", w_t'({mem_req, mem_addr}), w_t'({1'b1, 32'd4}));
    start = 1'b0; inc_cnt = 0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("bp_hold%0d", k), w_t'({mem_req, ins_valid, ins_pc, ins_data}),
          w_t'({1'b0, 1'b1, 32'd4, 32'h1004}));
    end
    chk("bp_single_inc", w_t'(inc_cnt), w_t'(1));
    chk("bp_pc_after_inc", w_t'(pc_in), w_t'(32'd5));
    ins_ready = 1'b1; lat = 3;

    // Redirect while WAIT is pending: orphan drained, stale word never shown.
    cyc(); chk("wr_req_pc5", w_t'({mem_req, mem_addr}), w_t'({1'b1, 32'd5}));
    cyc(); chk("wr_wait", w_t'({mem_req, ins_valid}), w_t'(0));
    br_valid = 1'b1; br_target = 32'h40;
    cyc(); chk("wr_load", w_t'({pc_load, pc_inc, pc_data, ins_valid, mem_req}),
               w_t'({1'b1, 1'b0, 32'h40, 1'b0, 1'b0}));
    br_valid = 1'b0;
    cyc(); chk("wr_flush_drop", w_t'({ins_valid, mem_req, pc_load}), w_t'(0));
    lat = 1;
    cyc(); chk("wr_new_addr", w_t'({mem_req, mem_addr}), w_t'({1'b1, 32'h40}));
    cyc(); chk("wr_no_stale", w_t'(ins_valid), w_t'(0));
    cyc(); chk("wr_target_data", w_t'({ins_valid, ins_pc, ins_data}),
               w_t'({1'b1, 32'h40, 32'h1040}));

    // Redirect colliding with rvalid: response dropped, no increment.
    cyc(); chk("coll_req", w_t'({mem_req, mem_addr}), w_t'({1'b1, 32'h41}));
    inc_cnt = 0;
    cyc(); br_valid = 1'b1; br_target = 32'h80;
    cyc(); chk("coll_redir", w_t'({pc_load, pc_inc, ins_valid, mem_req, pc_data}),
               w_t'({1'b1, 1'b0, 1'b0, 1'b0, 32'h80}));
    br_valid = 1'b0;
    cyc(); chk("coll_next_fetch", w_t'({mem_req, mem_addr, ins_valid}), w_t'({1'b1, 32'h80, 1'b0}));
    chk("coll_no_inc", w_t'(inc_cnt), w_t'(0));

    // Redirect in HOLD with ins_ready high: instruction dropped, not accepted.
    cyc();
    cyc(); chk("hr_shown", w_t'({ins_valid, ins_pc, ins_data}), w_t'({1'b1, 32'h80, 32'h1080}));
    br_valid = 1'b1; br_target = 32'h20;
    cyc(); chk("hr_drop", w_t'({ins_valid, pc_load, mem_req, pc_data}),
               w_t'({1'b0, 1'b1, 1'b0, 32'h20}));
    br_valid = 1'b0;
    cyc(); chk("hr_addr", w_t'({mem_req, mem_addr}), w_t'({1'b1, 32'h20}));

    // Halt on acceptance, then a redirect while IDLE only loads the counter.
    halt = 1'b1;
    cyc();
    cyc(); chk("halt_hold", w_t'({ins_valid, ins_pc, ins_data}), w_t'({1'b1, 32'h20, 32'h1020}));
    cyc(); chk("halt_idle", w_t'({mem_req, ins_valid}), w_t'(0));
    halt = 1'b0; br_valid = 1'b1; br_target = 32'h30;
    cyc(); chk("idle_br_load", w_t'({pc_load, pc_data, mem_req}), w_t'({1'b1, 32'h30, 1'b0}));
    br_valid = 1'b0;
    cyc(); chk("idle_stays", w_t'({mem_req, pc_load}), w_t'(0));
    chk("idle_br_pc", w_t'(pc_in), w_t'(32'h30));
    start = 1'b1; lat = 3;
    cyc(); chk("restart_req", w_t'({mem_req, mem_addr}), w_t'({1'b1, 32'h30}));
    start = 1'b0;

    // Asynchronous reset mid-WAIT; the late response must be ignored.
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_async", outs(), w_t'(0));
    cyc(); rst = 1'b0;
    cyc(); chk("rst_stray0", w_t'({ins_valid, mem_req, pc_inc}), w_t'(0));
    cyc(); chk("rst_stray1", w_t'({ins_valid, mem_req, pc_inc}), w_t'(0));
    start = 1'b1; lat = 1;
    cyc(); chk("rst_restart", w_t'({mem_req, mem_addr}), w_t'({1'b1, 32'd0}));
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
